// File: rtl/hd44780_pkg.sv
// Shared types and constants for the HD44780 4-bit bus receiver.
// Holds FSM states, command classes, bit indices and DDRAM line wrap points.
package hd44780_pkg;

    typedef enum logic [1:0] {
        MODE8 = 2'd0,
        HI    = 2'd1,
        LO    = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_CLEAR,
        CMD_HOME,
        CMD_DISPCTL,
        CMD_FUNCSET,
        CMD_SETDDRAM
    } cmd_e;

    localparam int DL_BIT = 4;
    localparam int D_BIT  = 2;

    localparam logic [6:0] LINE0_END   = 7'h27;
    localparam logic [6:0] LINE1_START = 7'h40;
    localparam logic [6:0] LINE1_END   = 7'h67;

    // The highest set bit of a command byte selects its class.
    function automatic cmd_e cmd_class(input logic [7:0] b);
        cmd_e c;
        if (b[7])      c = CMD_SETDDRAM;
        else if (b[6]) c = CMD_NONE;
        else if (b[5]) c = CMD_FUNCSET;
        else if (b[4]) c = CMD_NONE;
        else if (b[3]) c = CMD_DISPCTL;
        else if (b[2]) c = CMD_NONE;
        else if (b[1]) c = CMD_HOME;
        else if (b[0]) c = CMD_CLEAR;
        else           c = CMD_NONE;
        return c;
    endfunction

    // Post-write increment; out-of-range addresses jump to the next line start.
    function automatic logic [6:0] addr_inc(input logic [6:0] a);
        logic [6:0] n;
        if (a < LINE1_START) n = (a >= LINE0_END) ? LINE1_START : a + 7'd1;
        else                 n = (a >= LINE1_END) ? 7'd0 : a + 7'd1;
        return n;
    endfunction

endpackage

// File: rtl/hd44780_bus_sync.sv
// Two-flop synchronizer for E, RS, D[7:4] plus falling-edge detect on E.
// Ports: clk, rst, e_i/rs_i/d_i (async pins), strobe_o, rs_o, d_o (clk domain).
module hd44780_bus_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       e_i,
    input  logic       rs_i,
    input  logic [3:0] d_i,
    output logic       strobe_o,
    output logic       rs_o,
    output logic [3:0] d_o
);

    logic [5:0] s1_q;
    logic [5:0] s2_q;
    logic       e_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            e_prev_q <= 1'b0;
        end else begin
            s1_q     <= {e_i, rs_i, d_i};
            s2_q     <= s1_q;
            e_prev_q <= s2_q[5];
        end
    end

    assign strobe_o = e_prev_q & ~s2_q[5];
    assign rs_o     = s2_q[4];
    assign d_o      = s2_q[3:0];

endmodule

// File: rtl/hd44780_bus_rx.sv
// HD44780 bus receiver: reassembles strobed nibbles into bytes and tracks
// DDRAM address, display-on and 8/4-bit interface mode. Outputs registered.
module hd44780_bus_rx #(
    parameter int NIBBLE_TIMEOUT = 4095
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic [3:0] lcd_d,
    output logic       byte_valid,
    output logic       byte_rs,
    output logic [7:0] byte_data,
    output logic [6:0] ddram_addr,
    output logic       display_on,
    output logic       bus_4bit,
    output logic       nibble_pending,
    output logic       err
);
    import hd44780_pkg::*;

    localparam int CW = (NIBBLE_TIMEOUT < 2) ? 1 : $clog2(NIBBLE_TIMEOUT);

    logic       strobe;
    logic       s_rs;
    logic [3:0] s_d;

    hd44780_bus_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .e_i      (lcd_e),
        .rs_i     (lcd_rs),
        .d_i      (lcd_d),
        .strobe_o (strobe),
        .rs_o     (s_rs),
        .d_o      (s_d)
    );

    state_e          state_q, state_d;
    logic [3:0]      hi_q, hi_d;
    logic            hi_rs_q, hi_rs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [6:0]      addr_q, addr_d;
    logic            disp_q, disp_d;
    logic            valid_q, err_q, err_d;
    logic            brs_q, b4_q, pend_q;
    logic [7:0]      bdata_q;
    logic            emit;
    logic [7:0]      asm_byte;
    logic            asm_rs;
    cmd_e            cls;

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        hi_rs_d = hi_rs_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        disp_d  = disp_q;
        emit    = 1'b0;
        err_d   = 1'b0;
        if (state_q == MODE8) begin
            asm_byte = {s_d, 4'h0};
            asm_rs   = s_rs;
        end else begin
            asm_byte = {hi_q, s_d};
            asm_rs   = hi_rs_q;
        end
        cls = cmd_class(asm_byte);
        unique case (state_q)
            MODE8: emit = strobe;
            HI: begin
                if (strobe) begin
                    hi_d    = s_d;
                    hi_rs_d = s_rs;
                    cnt_d   = '0;
                    state_d = LO;
                end
            end
            LO: begin
                // A strobe in the timeout cycle still completes the byte.
                if (strobe) begin
                    emit    = 1'b1;
                    err_d   = (s_rs != hi_rs_q);
                    state_d = HI;
                end else if (cnt_q == CW'(NIBBLE_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = HI;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = MODE8;
        endcase
        if (emit) begin
            if (asm_rs) begin
                addr_d = addr_inc(addr_q);
            end else begin
                unique case (cls)
                    CMD_CLEAR,
                    CMD_HOME:     addr_d  = 7'd0;
                    CMD_DISPCTL:  disp_d  = asm_byte[D_BIT];
                    CMD_FUNCSET:  state_d = asm_byte[DL_BIT] ? MODE8 : HI;
                    CMD_SETDDRAM: addr_d  = asm_byte[6:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MODE8;
            hi_q    <= '0;
            hi_rs_q <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            disp_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            brs_q   <= 1'b0;
            bdata_q <= '0;
            b4_q    <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            hi_rs_q <= hi_rs_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            disp_q  <= disp_d;
            valid_q <= emit;
            err_q   <= err_d;
            b4_q    <= (state_d != MODE8);
            pend_q  <= (state_d == LO);
            if (emit) begin
                brs_q   <= asm_rs;
                bdata_q <= asm_byte;
            end
        end
    end

    assign byte_valid     = valid_q;
    assign byte_rs        = brs_q;
    assign byte_data      = bdata_q;
    assign ddram_addr     = addr_q;
    assign display_on     = disp_q;
    assign bus_4bit       = b4_q;
    assign nibble_pending = pend_q;
    assign err            = err_q;

endmodule

// File: tb/tb_hd44780_bus_rx.sv
// Self-checking bench for hd44780_bus_rx with a nibble-level reference model.
// Drives the LCD pins like a 4-clk-per-strobe writer and checks emitted bytes.
module tb_hd44780_bus_rx;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_e = 1'b0;
    logic       lcd_rs = 1'b0;
    logic [3:0] lcd_d = 4'h0;
    logic       byte_valid, byte_rs, display_on, bus_4bit;
    logic       nibble_pending, err;
    logic [7:0] byte_data;
    logic [6:0] ddram_addr;

    always #5 clk = ~clk;

    hd44780_bus_rx #(.NIBBLE_TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .lcd_e          (lcd_e),
        .lcd_rs         (lcd_rs),
        .lcd_d          (lcd_d),
        .byte_valid     (byte_valid),
        .byte_rs        (byte_rs),
        .byte_data      (byte_data),
        .ddram_addr     (ddram_addr),
        .display_on     (display_on),
        .bus_4bit       (bus_4bit),
        .nibble_pending (nibble_pending),
        .err            (err)
    );

    int n_checks = 0;
    int n_fail = 0;

    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    int got_err = 0;
    int exp_err = 0;

    always @(negedge clk) begin
        if (byte_valid) got_q.push_back({byte_rs, byte_data});
        if (err) got_err++;
    end

    // Reference model: display controller as seen from the writer side.
    bit         m4, mpend, mhrs, mdisp;
    logic [3:0] mhi;
    logic [6:0] maddr;

    function automatic void model_reset();
        m4 = 0; mpend = 0; mhrs = 0; mdisp = 0; mhi = 0; maddr = 0;
    endfunction

    function automatic void model_byte(bit rs, logic [7:0] b);
        exp_q.push_back({rs, b});
        if (rs) begin
            if (maddr >= 7'h27 && maddr < 7'h40) maddr = 7'h40;
            else if (maddr >= 7'h67) maddr = 7'h00;
            else maddr = maddr + 7'd1;
        end else if (b >= 8'h80) begin
            maddr = b[6:0];
        end else if (b >= 8'h40) begin
            maddr = maddr;
        end else if (b >= 8'h20) begin
            m4 = !b[4];
        end else if (b >= 8'h10) begin
            maddr = maddr;
        end else if (b >= 8'h08) begin
            mdisp = b[2];
        end else if (b >= 8'h04) begin
            maddr = maddr;
        end else if (b != 8'h00) begin
            maddr = 7'h00;
        end
    endfunction

    function automatic void model_nibble(bit rs, logic [3:0] d);
        if (!m4) begin
            model_byte(rs, {d, 4'h0});
        end else if (!mpend) begin
            mpend = 1; mhi = d; mhrs = rs;
        end else begin
            mpend = 0;
            if (rs != mhrs) exp_err++;
            model_byte(mhrs, {mhi, d});
        end
    endfunction

    // One strobe: E high 2 clk, low 2 clk, RS/D held across the fall.
    task automatic nib(input bit rs, input logic [3:0] d);
        lcd_rs = rs;
        lcd_d  = d;
        lcd_e  = 1'b1;
        repeat (2) @(negedge clk);
        lcd_e = 1'b0;
        model_nibble(rs, d);
        repeat (2) @(negedge clk);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({byte_valid, byte_rs, byte_data, ddram_addr, display_on,
             bus_4bit, nibble_pending, err} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h exp 0",
                     {byte_valid, byte_rs, byte_data, ddram_addr,
                      display_on, bus_4bit, nibble_pending, err});
        end
        rst = 1'b0;
        model_reset();
        settle();
    endtask

    task automatic test_powerup();
        logic [8:0] want [3];
        want = '{9'h030, 9'h020, 9'h00E};
        nib(0, 4'h3);
        settle();
        n_checks++;
        if (bus_4bit !== 1'b0) begin
            n_fail++;
            $display("FAIL pwr_mode8 got %b exp 0", bus_4bit);
        end
        nib(0, 4'h2);
        settle();
        n_checks++;
        if (bus_4bit !== 1'b1) begin
            n_fail++;
            $display("FAIL pwr_mode4 got %b exp 1", bus_4bit);
        end
        nib(0, 4'h0);
        nib(0, 4'hE);
        settle();
        n_checks++;
        if (display_on !== 1'b1) begin
            n_fail++;
            $display("FAIL pwr_disp got %b exp 1", display_on);
        end
        n_checks++;
        if (got_q.size() != 3) begin
            n_fail++;
            $display("FAIL pwr_count got %0d exp 3", got_q.size());
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== want[i]) begin
                n_fail++;
                $display("FAIL pwr_byte%0d got %h exp %h", i, got_q[i], want[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_data();
        logic [7:0] tbl [3];
        tbl = '{8'h48, 8'h65, 8'h48};
        for (int i = 0; i < 3; i++) begin
            nib(1, tbl[i][7:4]);
            nib(1, tbl[i][3:0]);
            settle();
            n_checks++;
            if (ddram_addr !== 7'(i + 1)) begin
                n_fail++;
                $display("FAIL data_addr%0d got %h exp %h", i, ddram_addr, i + 1);
            end
            n_checks++;
            if (got_q.size() != i + 1 || got_q[i] !== {1'b1, tbl[i]}) begin
                n_fail++;
                $display("FAIL data_byte%0d got %h exp %h", i,
                         got_q.size() > i ? got_q[i] : 9'h1ff, {1'b1, tbl[i]});
            end
        end
        nib(1, 4'h0);
        settle();
        n_checks++;
        if (nibble_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL data_pending got %b exp 1", nibble_pending);
        end
        repeat (TO + 4) @(negedge clk);
        mpend = 0;
        exp_err++;
        n_checks++;
        if (nibble_pending !== 1'b0 || got_err != exp_err) begin
            n_fail++;
            $display("FAIL data_lone_drop got pend=%b err=%0d exp pend=0 err=%0d",
                     nibble_pending, got_err, exp_err);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_timeout();
        int p_at, e_at;
        logic [3:0] a, b;
        bit pend_at_err;
        p_at = -1;
        e_at = -1;
        pend_at_err = 1'b1;
        nib(1, 4'($urandom_range(15, 0)));
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (p_at < 0 && nibble_pending) p_at = k;
            if (e_at < 0 && err) begin
                e_at = k;
                pend_at_err = nibble_pending;
            end
        end
        mpend = 0;
        exp_err++;
        n_checks++;
        if (p_at < 0 || e_at < 0 || e_at - p_at != TO) begin
            n_fail++;
            $display("FAIL timeout_delay got %0d exp %0d", e_at - p_at, TO);
        end
        n_checks++;
        if (pend_at_err !== 1'b0 || got_err != exp_err) begin
            n_fail++;
            $display("FAIL timeout_drop got pend=%b err=%0d exp pend=0 err=%0d",
                     pend_at_err, got_err, exp_err);
        end
        a = 4'($urandom_range(15, 0));
        b = 4'($urandom_range(15, 0));
        nib(1, a);
        nib(1, b);
        settle();
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== {1'b1, a, b}
            || ddram_addr !== maddr) begin
            n_fail++;
            $display("FAIL timeout_next got %h addr %h exp %h addr %h",
                     got_q.size() > 0 ? got_q[0] : 9'h1ff, ddram_addr,
                     {1'b1, a, b}, maddr);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_wrap();
        logic [7:0] cmd [5];
        logic [6:0] want [5];
        cmd  = '{8'hA7, 8'hE7, 8'hB0, 8'hF0, 8'h85};
        want = '{7'h40, 7'h00, 7'h40, 7'h00, 7'h06};
        for (int i = 0; i < 5; i++) begin
            nib(0, cmd[i][7:4]);
            nib(0, cmd[i][3:0]);
            nib(1, 4'($urandom_range(15, 0)));
            nib(1, 4'($urandom_range(15, 0)));
            settle();
            n_checks++;
            if (ddram_addr !== want[i]) begin
                n_fail++;
                $display("FAIL wrap_%h got %h exp %h", cmd[i], ddram_addr, want[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_mismatch();
        logic [3:0] a, b;
        a = 4'($urandom_range(15, 0));
        b = 4'($urandom_range(15, 0));
        nib(1, a);
        nib(0, b);
        settle();
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== {1'b1, a, b}) begin
            n_fail++;
            $display("FAIL mismatch_byte got %h exp %h",
                     got_q.size() > 0 ? got_q[0] : 9'h1ff, {1'b1, a, b});
        end
        n_checks++;
        if (got_err != exp_err) begin
            n_fail++;
            $display("FAIL mismatch_err got %0d exp %0d", got_err, exp_err);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        nib(1, 4'h5);
        @(negedge clk);
        n_checks++;
        if (nibble_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pending got %b exp 1", nibble_pending);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({byte_valid, byte_rs, byte_data, ddram_addr, display_on,
             bus_4bit, nibble_pending, err} !== 22'd0) begin
            n_fail++;
            $display("FAIL rstmid_outputs got %h exp 0",
                     {byte_valid, byte_rs, byte_data, ddram_addr,
                      display_on, bus_4bit, nibble_pending, err});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (TO + 4) @(negedge clk);
        n_checks++;
        if (got_q.size() != 0 || bus_4bit !== 1'b0 || got_err != exp_err) begin
            n_fail++;
            $display("FAIL rstmid_quiet got bytes=%0d b4=%b err=%0d exp 0 0 %0d",
                     got_q.size(), bus_4bit, got_err, exp_err);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_funcset8();
        logic [3:0] d;
        nib(0, 4'h2);
        nib(0, 4'h3);
        nib(0, 4'h0);
        settle();
        n_checks++;
        if (bus_4bit !== 1'b0) begin
            n_fail++;
            $display("FAIL fs8_mode got %b exp 0", bus_4bit);
        end
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            d = 4'($urandom_range(15, 0));
            nib(1, d);
            settle();
            n_checks++;
            if (got_q.size() != 1 || got_q[0] !== {1'b1, d, 4'h0}) begin
                n_fail++;
                $display("FAIL fs8_byte%0d got %h exp %h", i,
                         got_q.size() > 0 ? got_q[0] : 9'h1ff, {1'b1, d, 4'h0});
            end
            got_q.delete();
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        bad = 0;
        for (int i = 0; i < 200; i++)
            nib(1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)));
        settle();
        if (mpend) begin
            repeat (TO + 4) @(negedge clk);
            mpend = 0;
            exp_err++;
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (got_q[i] !== exp_q[i] && bad == 0) bad = i + 1;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL b2b_byte%0d got %h exp %h", bad - 1,
                     got_q[bad - 1], exp_q[bad - 1]);
        end
        n_checks++;
        if (ddram_addr !== maddr || display_on !== mdisp || bus_4bit !== m4
            || nibble_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_state got %h %b %b %b exp %h %b %b 0",
                     ddram_addr, display_on, bus_4bit, nibble_pending,
                     maddr, mdisp, m4);
        end
        n_checks++;
        if (got_err != exp_err) begin
            n_fail++;
            $display("FAIL b2b_err got %0d exp %0d", got_err, exp_err);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_powerup();
        test_data();
        test_timeout();
        test_wrap();
        test_mismatch();
        test_reset_mid();
        test_funcset8();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hd44780_bus_rx.md
# hd44780_bus_rx

Receiver/decoder for the HD44780-style 4-bit parallel LCD bus (E strobe, RS, D[7:4]) that our LCD writer drives. It samples the asynchronous bus pins, follows the 8-bit/4-bit interface mode switch, reassembles nibble pairs into bytes, and tracks controller state: DDRAM address and display-on. It is the display-side model used for loopback self-test and as an on-chip sniffer of the LCD pins.

## Interface
Parameters:
- NIBBLE_TIMEOUT, 4095: clk cycles a pending high nibble may wait for its low nibble before it is discarded (≥1).

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- lcd_e  in  1  enable strobe, asynchronous; data latched on its falling edge
- lcd_rs  in  1  register select (0 = command, 1 = data), asynchronous
- lcd_d  in  4  bus D[7:4], asynchronous
- byte_valid  out  1  one-cycle pulse, completed byte
- byte_rs  out  1  RS of completed byte
- byte_data  out  8  completed byte
- ddram_addr  out  7  current DDRAM address
- display_on  out  1  display-control D bit
- bus_4bit  out  1  1 = 4-bit interface mode
- nibble_pending  out  1  high nibble held, low nibble awaited
- err  out  1  one-cycle pulse: timeout discard or RS mismatch

## Operation
- All reset values are 0: byte_valid, byte_rs, byte_data, ddram_addr, display_on, bus_4bit, nibble_pending, err, internal state. Reset puts the block in 8-bit mode.
- lcd_e, lcd_rs, lcd_d each pass through a 2-flop synchronizer. A strobe is a falling edge of synchronized E. RS/D are taken from the synchronized copies in the same cycle.
- State machine, states MODE8, HI, LO:
  - MODE8: each strobe is one byte {lcd_d, 4'b0000}. Emit it and go to HI if it is a function set with DL=0.
  - HI: strobe stores the nibble and its RS, then goes to LO.
  - LO: strobe emits {hi, lcd_d} and goes to HI. If the emitted byte is a function set with DL=1, go to MODE8 instead.
- RS mismatch between the two nibbles: byte_rs takes the high-nibble RS, the byte is still emitted, and err pulses.
- Timeout: in LO, the counter counts cycles since the high nibble. When it reaches NIBBLE_TIMEOUT, the nibble is dropped, err pulses, and state returns to HI. If the timeout and a strobe occur in the same cycle, the strobe wins and the byte completes normally.
- Decode of emitted bytes with RS=0 (highest set bit decides):
  - 0x01 clear: addr←0.
  - 0x02/0x03 home: addr←0.
  - 0x04–0x07 entry mode: ignored; the block always increments.
  - 0x08–0x0F: display_on←bit2.
  - 0x10–0x1F shift: ignored.
  - 0x20–0x3F: function set, bit4 = DL.
  - 0x40–0x7F CGRAM: ignored.
  - 0x80|a: addr←a.
- RS=1 byte: addr increments after the write, wrapping 0x27→0x40 and 0x67→0x00. A set-DDRAM address outside the valid ranges is stored as given. From such an address, increment goes to 0x40 if addr<0x40, otherwise to 0x00.
- nibble_pending = (state==LO).

## Timing
- A strobe is recognized in the cycle in which synchronized E (2nd flop) is 0 and its previous value was 1.
- byte_valid, byte_rs, byte_data, err, bus_4bit, display_on and ddram_addr are registered. They update at the clock edge ending the detection cycle, 3 rising edges after lcd_e is first sampled low.
- Bus requirement: E high ≥2 clk, E low ≥2 clk, RS/D stable from 2 clk before the E fall to 1 clk after it.
- Back-to-back strobes every 4 clk are accepted with no loss. There is no backpressure; byte_valid is a pulse only.
- Asynchronous reset mid-byte clears any pending nibble immediately. No byte is emitted for it.

## Structure
- hd44780_pkg:
  - state enum (MODE8, HI, LO)
  - command-class constants: CMD_CLEAR, CMD_HOME, CMD_DISPCTL, CMD_FUNCSET, CMD_SETDDRAM
  - bit indices DL_BIT=4, D_BIT=2
  - line wrap constants 0x27, 0x40, 0x67
- Sub-module hd44780_bus_sync: 2-flop synchronizer for the 6 input bits plus the E falling-edge detector. It outputs strobe, rs, d.
- The top module holds the FSM, timeout counter, nibble register and decode/address logic.

## Test plan
- Writer's power-up stream: RS=0 nibbles 0x3, 0x2, 0x0, 0xE. Expect bytes 0x30, 0x20, 0x0E. bus_4bit=1 after the 2nd byte; display_on=1 after the 3rd.
- Continue with RS=1 pairs 4/8, 6/5, 4/8. Expect bytes 0x48, 0x65, 0x48 with byte_rs=1 and ddram_addr 0→1→2→3. A trailing lone RS=1 0x0 leaves nibble_pending=1.
- 4-bit mode: command 0xA7, then one data byte. Expect addr 0x27→0x40. Command 0xE7 then data: expect addr 0x67→0x00.
- NIBBLE_TIMEOUT=16, high nibble then silence. Expect err pulse 16 cycles later, nibble_pending→0, and the next pair decodes correctly.
- Pair with RS 1 then 0, plus rst asserted between nibbles of another pair. Expect err with byte_rs=1 for the first; on reset all outputs→0, bus_4bit=0, no byte emitted.
- 4-bit function set 0x30. Expect bus_4bit→0, after which single strobes give 0x?0 bytes.
